// File: rtl/wire_response_checker.sv
// Response checker for a 2-in/2-out wire DUT: waits for {w,x} to settle, compares {y,z}
// against EXP_TABLE and keeps pass/fail statistics. Optional input synchronizers: WIRE_CHK_SYNC_EN.
module wire_response_checker #(
  parameter logic [7:0] EXP_TABLE     = 8'hE4,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         NUM_VECTORS   = 5,
  parameter int         CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT_CHG, DONE} state_t;

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] NUM_VEC     = CNT_W'(NUM_VECTORS);

  logic [3:0] raw_in;
  logic [3:0] in_s;

  assign raw_in = {w, x, y, z};

`ifdef WIRE_CHK_SYNC_EN
  // Each of w,x,y,z gets its own 2-flop synchronizer; everything downstream sees in_s only.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      logic s1_q, s2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
        end else begin
          s1_q <= raw_in[gi];
          s2_q <= s1_q;
        end
      end
      assign in_s[gi] = s2_q;
    end
  endgenerate
`else
  assign in_s = raw_in;
`endif

  logic [1:0] wx;
  logic [1:0] yz;
  logic [1:0] exp_yz;
  logic       changed;
  logic       mismatch;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       prev_wx_q, prev_wx_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [3:0]       ff_q, ff_d;

  assign wx       = in_s[3:2];
  assign yz       = in_s[1:0];
  assign exp_yz   = EXP_TABLE[{wx, 1'b0} +: 2];
  assign changed  = (wx != prev_wx_q);
  assign mismatch = (yz != exp_yz);
  assign prev_wx_d = wx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_wx_q <= '0;
      vec_q     <= '0;
      err_q     <= '0;
      ff_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_wx_q <= prev_wx_d;
      vec_q     <= vec_d;
      err_q     <= err_d;
      ff_q      <= ff_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ff_d    = ff_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // stop wins over a pending check, so no count update slips through on abort
        if (stop) begin
          state_d = IDLE;
        end else if (changed) begin
          cnt_d = SETTLE_LOAD;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          vec_d = vec_q + 1'b1;
          if (mismatch) begin
            if (err_q != CNT_MAX) err_d = err_q + 1'b1;
            if (err_q == '0)      ff_d  = in_s;
          end
          state_d = (vec_d == NUM_VEC) ? DONE : WAIT_CHG;
        end
      end
      WAIT_CHG: begin
        if (stop) begin
          state_d = IDLE;
        end else if (changed) begin
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          vec_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SETTLE) || (state_q == WAIT_CHG);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (err_q == '0);
  end

  assign vec_count  = vec_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_wire_response_checker.sv
// Randomized and directed bench for wire_response_checker; expected results come from a
// run-length model of the input sequence (a run of S+1 or more edges yields one check).
module tb_wire_response_checker;

  localparam logic [7:0] EXP = 8'hE4;
  localparam int         S   = 4;
`ifdef WIRE_CHK_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, start_s = 1'b0, stop_s = 1'b0;
  logic w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;
  logic y_n, z_n;

  logic       busy, done, pass;
  logic [7:0] vec_count, err_count;
  logic [3:0] first_fail;
  logic       busy_s, done_s, pass_s;
  logic [1:0] vec_s, err_s;
  logic [3:0] ff_s;

  assign y_n = ~y;
  assign z_n = ~z;

  always #5 clk = ~clk;

  wire_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .w(w), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .first_fail(first_fail)
  );

  wire_response_checker #(.CNT_W(2), .NUM_VECTORS(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .stop(stop_s),
    .w(w), .x(x), .y(y_n), .z(z_n),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .vec_count(vec_s), .err_count(err_s), .first_fail(ff_s)
  );

  int n_vec = 0;
  int n_bad = 0;

  int         seg_wx[$];
  int         seg_len[$];
  logic [7:0] dut_tbl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wx(input int v);
    {w, x} = 2'(v);
    {y, z} = 2'(dut_tbl >> (2 * v));
  endtask

  // Groups equal consecutive segments into runs; each run held >= S+1 edges is checked once.
  function automatic void model(input int numv, input int maxerr, input bit inv,
                                output int e_vec, output int e_err, output int e_ff,
                                output int e_done);
    int rw[$];
    int rl[$];
    logic [1:0] yz, ex;
    foreach (seg_wx[i]) begin
      if (rw.size() > 0 && rw[rw.size()-1] == seg_wx[i])
        rl[rl.size()-1] = rl[rl.size()-1] + seg_len[i];
      else begin
        rw.push_back(seg_wx[i]);
        rl.push_back(seg_len[i]);
      end
    end
    rl[0] = rl[0] + SYNC_LAT;
    e_vec = 0; e_err = 0; e_ff = 0; e_done = 0;
    foreach (rw[i]) begin
      if (e_done != 0) break;
      if (rl[i] >= S + 1) begin
        yz = 2'(dut_tbl >> (2 * rw[i])) ^ (inv ? 2'b11 : 2'b00);
        ex = 2'(EXP >> (2 * rw[i]));
        e_vec++;
        if (yz != ex) begin
          if (e_err == 0) e_ff = {2'(rw[i]), yz};
          e_err = (e_err < maxerr) ? e_err + 1 : maxerr;
        end
        if (e_vec == numv) e_done = 1;
      end
    end
  endfunction

  task automatic run_trial(input string tag, input bit use_sat);
    int e_vec, e_err, e_ff, e_done;
    stop = 1'b1; stop_s = 1'b1;
    tick();
    stop = 1'b0; stop_s = 1'b0;
    set_wx(seg_wx[0]);
    repeat (3) tick();
    for (int i = 0; i < seg_wx.size(); i++) begin
      for (int c = 0; c < seg_len[i]; c++) begin
        set_wx(seg_wx[i]);
        if (i == 0 && c == 0) begin
          if (use_sat) start_s = 1'b1; else start = 1'b1;
        end
        tick();
        start = 1'b0; start_s = 1'b0;
      end
    end
    if (use_sat) begin
      model(3, 3, 1'b1, e_vec, e_err, e_ff, e_done);
      chk({tag, "_vec"},  32'(vec_s),  32'(e_vec));
      chk({tag, "_err"},  32'(err_s),  32'(e_err));
      chk({tag, "_ff"},   32'(ff_s),   32'(e_ff));
      chk({tag, "_done"}, 32'(done_s), 32'(e_done));
      chk({tag, "_busy"}, 32'(busy_s), 32'(e_done == 0));
      chk({tag, "_pass"}, 32'(pass_s), 32'(e_done != 0 && e_err == 0));
    end else begin
      model(5, 255, 1'b0, e_vec, e_err, e_ff, e_done);
      chk({tag, "_vec"},  32'(vec_count),  32'(e_vec));
      chk({tag, "_err"},  32'(err_count),  32'(e_err));
      chk({tag, "_ff"},   32'(first_fail), 32'(e_ff));
      chk({tag, "_done"}, 32'(done),       32'(e_done));
      chk({tag, "_busy"}, 32'(busy),       32'(e_done == 0));
      chk({tag, "_pass"}, 32'(pass),       32'(e_done != 0 && e_err == 0));
    end
  endtask

  task automatic std_seq();
    seg_wx  = '{0, 2, 3, 1, 0};
    seg_len = '{20, 20, 20, 20, 20};
  endtask

  initial begin
    dut_tbl = EXP;

    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      {w, x, y, z} = 4'($urandom);
      #3;
    end
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_vec",  32'(vec_count), 0);
    chk("rst_err",  32'(err_count), 0);
    chk("rst_ff",   32'(first_fail), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      {w, x, y, z} = 4'($urandom);
      tick();
    end
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_vec",  32'(vec_count), 0);

    // passthrough, then start+stop from DONE, then restart
    dut_tbl = EXP;
    std_seq();
    run_trial("passthru", 1'b0);
    chk("passthru_pass_const", 32'(pass), 1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_done", 32'(done), 0);
    chk("startstop_busy", 32'(busy), 0);
    chk("startstop_vec",  32'(vec_count), 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_vec",  32'(vec_count), 0);
    chk("restart_err",  32'(err_count), 0);

    // z stuck at 0
    dut_tbl = 8'hA0;
    std_seq();
    run_trial("zstuck", 1'b0);

    // glitch: w toggles every 2 cycles, then holds
    dut_tbl = EXP;
    seg_wx  = '{0};
    seg_len = '{10};
    run_trial("glitch_pre", 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_wx((i % 2 == 0) ? 2 : 0);
      tick();
      chk($sformatf("glitch_tog%0da", i), 32'(vec_count), 1);
      tick();
      chk($sformatf("glitch_tog%0db", i), 32'(vec_count), 1);
    end
    set_wx(2);
    for (int k = 1; k <= S + 1 + SYNC_LAT + 4; k++) begin
      tick();
      if (k == S + SYNC_LAT)     chk("glitch_before", 32'(vec_count), 1);
      if (k == S + 1 + SYNC_LAT) chk("glitch_at",     32'(vec_count), 2);
    end
    chk("glitch_once", 32'(vec_count), 2);

    // stop asserted on the very cycle a check would happen
    set_wx(3);
    for (int k = 1; k <= S + 1 + SYNC_LAT; k++) begin
      if (k == S + 1 + SYNC_LAT) stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    chk("abort_vec",  32'(vec_count), 2);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);

    // randomized sequences
    for (int t = 0; t < 8; t++) begin
      int nseg;
      dut_tbl = ($urandom_range(0, 1) == 0) ? EXP : 8'($urandom);
      nseg = $urandom_range(3, 9);
      seg_wx.delete();
      seg_len.delete();
      for (int i = 0; i < nseg; i++) begin
        seg_wx.push_back($urandom_range(0, 3));
        seg_len.push_back((i == nseg - 1) ? 12 : $urandom_range(1, 8));
      end
      run_trial($sformatf("rand%0d", t), 1'b0);
    end

    // saturating error counter on the narrow instance
    dut_tbl = EXP;
    seg_wx  = '{0, 1, 2, 3};
    seg_len = '{10, 10, 10, 10};
    run_trial("sat", 1'b1);
    set_wx(1);
    repeat (12) tick();
    chk("sat_hold_err", 32'(err_s), 3);

    // reset asserted in the middle of a settle window
    set_wx(2);
    start_s = 1'b1; start = 1'b1;
    tick();
    start_s = 1'b0; start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_s", 32'(busy_s), 0);
    chk("midrst_vec_s",  32'(vec_s), 0);
    chk("midrst_err_s",  32'(err_s), 0);
    chk("midrst_ff_s",   32'(ff_s), 0);
    chk("midrst_busy",   32'(busy), 0);
    chk("midrst_vec",    32'(vec_count), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("midrst_after_vec_s", 32'(vec_s), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
